// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-path types and constants.
//   XLEN          default address/data width
//   ILEN          instruction word width
//   INST_NOP      canonical RISC-V nop (addi x0,x0,0)
//   fetch_entry_t buffered instruction with its PC
//   align_word()  clears the byte-offset bits of a PC
package riscv_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  // Masking keeps every input bit referenced while forcing [1:0] to zero.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// DEPTH-entry FIFO of fetch_entry_t with synchronous flush.
//   clk, rst    clock, asynchronous active-high reset
//   flush       drop all entries this cycle (wins over push/pop)
//   push        write push_data at the tail
//   pop         advance the head (ignored when empty)
//   head        entry at the head (registered storage)
//   empty       no entries held
//   count       number of entries held, 0..DEPTH
module inst_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            pop_ok;

  assign pop_ok = pop && (count_q != '0);

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/inst_prefetch.sv
// Decoupled instruction-fetch front end. Owns the PC, issues in-order word
// reads, buffers returned words with their PCs and offers them to decode.
// A redirect flushes the buffer and marks in-flight reads for discard so the
// target is fetched without waiting for stale responses.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req_valid/ready, addr     read request channel (addr word aligned)
//   imem_rsp_valid, imem_rsp_data  in-order read data
//   redirect_valid, redirect_pc    taken branch/jump, restart fetch
//   inst_valid/ready, inst, pc     instruction hand-off to decode
//
// Build option: define IPREFETCH_BYPASS_EN to forward a response straight to
// decode in the same cycle when the buffer is empty, nothing is being dropped,
// no redirect is present and decode is ready.
module inst_prefetch
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = riscv_fetch_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int unsigned CNTW = $clog2(DEPTH) + 1;
  localparam int unsigned SUMW = CNTW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNTW-1:0] inflight_q, inflight_d;
  logic [CNTW-1:0] drop_q, drop_d;

  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wdata;
  logic            fifo_empty;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_push;
  logic            fifo_pop;

  logic            issue_ok;
  logic            req_accept;
  logic            rsp_live;
  logic            bypass;

  // Credit: buffered plus outstanding never exceeds DEPTH, so every response
  // (dropped ones included) has a slot reserved until it returns.
  assign issue_ok   = !redirect_valid &&
                      ((SUMW'(fifo_count) + SUMW'(inflight_q)) < SUMW'(DEPTH));
  assign req_accept = issue_ok && imem_req_ready;

  // A response is kept only outside a redirect cycle and once stale reads are drained.
  assign rsp_live = imem_rsp_valid && !redirect_valid && (drop_q == '0);

`ifdef IPREFETCH_BYPASS_EN
  assign bypass = rsp_live && fifo_empty && inst_ready;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push  = rsp_live && !bypass;
  assign fifo_pop   = !redirect_valid && !fifo_empty && inst_ready;
  assign fifo_wdata = '{pc: rsp_pc_q, inst: imem_rsp_data};

  // Fetch pointer, response PC tracker and outstanding/drop accounting.
  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CNTW'(req_accept) - CNTW'(imem_rsp_valid);
    drop_d     = drop_q;
    if (redirect_valid) begin
      pc_d     = align_word(redirect_pc);
      rsp_pc_d = align_word(redirect_pc);
      // Everything still outstanding after this cycle's response is stale.
      drop_d   = inflight_q - CNTW'(imem_rsp_valid);
    end else begin
      if (req_accept) begin
        pc_d = pc_q + XLEN'(4);
      end
      if (rsp_live) begin
        rsp_pc_d = rsp_pc_q + XLEN'(4);
      end
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Reset only masks the request port; internal state is already held by the flops.
  assign imem_req_valid = issue_ok && !rst;
  assign imem_addr      = pc_q;

  assign inst_valid = !redirect_valid && (!fifo_empty || bypass);
  assign inst       = bypass ? imem_rsp_data : fifo_head.inst;
  assign inst_pc    = bypass ? rsp_pc_q      : fifo_head.pc;

`ifndef SYNTHESIS
  rsp_without_request : assert property (
    @(posedge clk) disable iff (rst) !(imem_rsp_valid && (inflight_q == '0))
  );
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// Bench for inst_prefetch (DEPTH=4, RESET_PC=0). Memory returns in order after
// a configurable latency; a queue-based model of decode-visible instructions
// is compared every cycle, plus directed literal expectations per scenario.
module tb_inst_prefetch;
  import riscv_fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  inst_prefetch #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } mem_req_t;

  mem_req_t     mem_q[$];   // accepted reads not yet answered
  fetch_entry_t buf_q[$];   // instructions decode is entitled to see, in order
  logic [31:0]  exp_addr;   // next address the front end must request
  int           cyc;
  int           mem_lat;
  int           checks;
  int           failures;

  logic [31:0]  acc_log[$];
  logic [31:0]  pop_pc[$];
  logic [31:0]  pop_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic logic [63:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return 64'(q[i]);
    return '1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: present memory response, compare against the model, advance both.
  task automatic step();
    logic     exp_rv;
    logic     exp_iv;
    mem_req_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end
    #1;
    exp_rv = !redirect_valid && ((buf_q.size() + mem_q.size()) < DEPTH);
    exp_iv = !redirect_valid && (buf_q.size() > 0);
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (exp_rv) chk("imem_addr", 64'(imem_addr), 64'(exp_addr));
    chk("inst_valid", 64'(inst_valid), 64'(exp_iv));
    if (exp_iv) begin
      chk("inst_pc", 64'(inst_pc), 64'(buf_q[0].pc));
      chk("inst", 64'(inst), 64'(buf_q[0].inst));
    end
    if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_addr);
    if (inst_valid && inst_ready) begin
      pop_pc.push_back(inst_pc);
      pop_cyc.push_back(32'(cyc));
    end
    if (exp_iv && inst_ready) void'(buf_q.pop_front());
    if (imem_rsp_valid) begin
      r = mem_q.pop_front();
      if (!redirect_valid && !r.stale) buf_q.push_back('{pc: r.addr, inst: mem_word(r.addr)});
    end
    if (redirect_valid) begin
      buf_q.delete();
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_addr = redirect_pc & ~32'd3;
    end
    if (imem_req_valid && imem_req_ready) begin
      mem_q.push_back('{addr: imem_addr, due: cyc + mem_lat, stale: 1'b0});
      if (!redirect_valid) exp_addr = exp_addr + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    mem_lat        = 1;
    mem_q.delete();
    buf_q.delete();
    acc_log.delete();
    pop_pc.delete();
    pop_cyc.delete();
    exp_addr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
    chk("rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("rst_addr", 64'(imem_addr), 64'(0));
    chk("rst_inst", 64'(inst), 64'(0));
    chk("rst_inst_pc", 64'(inst_pc), 64'(0));
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;

    // 1: streaming, first instruction two cycles after reset release
    do_reset();
    inst_ready = 1'b1;
    repeat (10) step();
    chk("t1_first_cyc", qget(pop_cyc, 0), 64'(2));
    chk("t1_first_pc", qget(pop_pc, 0), 64'(32'h0));
    chk("t1_pop_count", 64'(pop_pc.size()), 64'(8));
    chk("t1_last_pc", qget(pop_pc, 7), 64'(32'h1C));
    chk("t1_addr2", qget(acc_log, 2), 64'(32'h8));

    // 2: decode stalled, credit stops issue at DEPTH, then drains in order
    do_reset();
    repeat (8) step();
    chk("t2_issued", 64'(acc_log.size()), 64'(4));
    #1;
    chk("t2_req_low", 64'(imem_req_valid), 64'(0));
    inst_ready = 1'b1;
    repeat (8) step();
    chk("t2_pop0", qget(pop_pc, 0), 64'(32'h0));
    chk("t2_pop1", qget(pop_pc, 1), 64'(32'h4));
    chk("t2_pop2", qget(pop_pc, 2), 64'(32'h8));
    chk("t2_pop3", qget(pop_pc, 3), 64'(32'hC));
    chk("t2_resume_addr", qget(acc_log, 4), 64'(32'h10));
    chk("t2_pop4", qget(pop_pc, 4), 64'(32'h10));

    // 3: latency 3, redirect with two reads in flight
    do_reset();
    mem_lat    = 3;
    inst_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    repeat (8) step();
    chk("t3_redirect_addr", qget(acc_log, 2), 64'(32'h40));
    chk("t3_first_pc", qget(pop_pc, 0), 64'(32'h40));
    chk("t3_first_cyc", qget(pop_cyc, 0), 64'(7));

    // 4: redirect coincides with a response and a ready decode
    do_reset();
    mem_lat    = 2;
    inst_ready = 1'b1;
    repeat (6) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    repeat (6) step();
    chk("t4_last_pre_cyc", qget(pop_cyc, 2), 64'(5));
    chk("t4_post_cyc", qget(pop_cyc, 3), 64'(10));
    chk("t4_post_pc", qget(pop_pc, 3), 64'(32'h100));
    chk("t4_redirect_addr", qget(acc_log, 6), 64'(32'h100));

    // 5: async reset with three buffered instructions
    do_reset();
    repeat (4) step();
    #1;
    chk("t5_pre_valid", 64'(inst_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("t5_rst_inst_valid", 64'(inst_valid), 64'(0));
    chk("t5_rst_req_valid", 64'(imem_req_valid), 64'(0));
    do_reset();
    step();
    chk("t5_restart_addr", qget(acc_log, 0), 64'(32'h0));

    // 6: memory back-pressure, then an unaligned redirect
    do_reset();
    inst_ready     = 1'b1;
    imem_req_ready = 1'b0;
    repeat (5) step();
    chk("t6_none_accepted", 64'(acc_log.size()), 64'(0));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h83;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    repeat (4) step();
    chk("t6_redirect_addr", qget(acc_log, 0), 64'(32'h80));
    chk("t6_first_pc", qget(pop_pc, 0), 64'(32'h80));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
